hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock. It tracks destination/Tnew per stage and raises stall on RAW hazards.
// Optional MDU busy interlock enabled by defining HAZARD_MDU_STALL_EN.
`default_nettype none

module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1D,
    input  logic [4:0] A2D,
    input  logic [1:0] TuseRsD,
    input  logic [1:0] TuseRtD,
    input  logic [4:0] A3D,
    input  logic [1:0] TnewD,
    input  logic       mdD,
    input  logic [1:0] mdOpD,
    output logic       stall,
    output logic [4:0] A3E,
    output logic [4:0] A3M,
    output logic [4:0] A3W,
    output logic       md_busy
);

    logic [4:0] a3E_q, a3E_d, a3M_q, a3M_d, a3W_q, a3W_d;
    logic [1:0] tnewE_q, tnewE_d, tnewM_q, tnewM_d;
    logic       rs_stall, rt_stall, md_stall;

    // The nearest stage owning the register decides; W has always produced its result.
    function automatic logic src_stall(input logic [4:0] a, input logic [1:0] tuse,
                                       input logic [4:0] ae, input logic [1:0] te,
                                       input logic [4:0] am, input logic [1:0] tm);
        logic s;
        s = 1'b0;
        if (tuse != 2'd3 && a != 5'd0) begin
            if (a == ae)
                s = (te > tuse);
            else if (a == am)
                s = (tm > tuse);
        end
        return s;
    endfunction

    always_comb begin
        rs_stall = src_stall(A1D, TuseRsD, a3E_q, tnewE_q, a3M_q, tnewM_q);
        rt_stall = src_stall(A2D, TuseRtD, a3E_q, tnewE_q, a3M_q, tnewM_q);
        stall    = rs_stall | rt_stall | md_stall;
    end

    always_comb begin
        a3E_d   = stall ? 5'd0 : A3D;
        tnewE_d = stall ? 2'd0 : TnewD;
        a3M_d   = a3E_q;
        tnewM_d = (tnewE_q == 2'd0) ? 2'd0 : tnewE_q - 2'd1;
        a3W_d   = a3M_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a3E_q   <= 5'd0;
            tnewE_q <= 2'd0;
            a3M_q   <= 5'd0;
            tnewM_q <= 2'd0;
            a3W_q   <= 5'd0;
        end else begin
            a3E_q   <= a3E_d;
            tnewE_q <= tnewE_d;
            a3M_q   <= a3M_d;
            tnewM_q <= tnewM_d;
            a3W_q   <= a3W_d;
        end
    end

`ifdef HAZARD_MDU_STALL_EN
    logic [3:0] mdCnt_q, mdCnt_d;

    // A new mult/div is only accepted on an unstalled edge; reserved op 3 behaves like none.
    always_comb begin
        mdCnt_d = (mdCnt_q != 4'd0) ? mdCnt_q - 4'd1 : 4'd0;
        if (!stall) begin
            if (mdOpD == 2'd1)
                mdCnt_d = 4'd5;
            else if (mdOpD == 2'd2)
                mdCnt_d = 4'd10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mdCnt_q <= 4'd0;
        else
            mdCnt_q <= mdCnt_d;
    end

    assign md_busy  = (mdCnt_q != 4'd0);
    assign md_stall = mdD & md_busy;
`else
    logic md_unused;
    assign md_unused = ^{mdD, mdOpD};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign A3E = a3E_q;
    assign A3M = a3M_q;
    assign A3W = a3W_q;

endmodule

`default_nettype wire
